// File: rtl/muldiv_unit.sv
// Sequential signed 32x32 multiply (radix-2 Booth) and divide (restoring, MULDIV_DIV_EN).
// Latency: 33 cycles start-to-done for MULT and non-zero DIV; 1 cycle for DIV by zero or DIV compiled out.
// Backpressure: none; start is only sampled in IDLE and is dropped while busy or done.
module muldiv_unit (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        busy,
    output logic        done,
    output logic        div_zero
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [5:0]  iterCnt;
    logic [31:0] aReg;
    // MULT view: {acc[64:33], multiplier[32:1], q-1[0]}; DIV view: {rem[64:32], quotient[31:0]}
    logic [64:0] work;
    logic [64:0] workNext;
    logic [31:0] resHi;
    logic [31:0] resLo;

    logic [32:0] accExt;
    logic [32:0] boothSum;
    logic [64:0] mulNext;

    // The sum is kept one bit wider so that subtracting the most negative multiplicand
    // cannot overflow; its true sign becomes the shifted-in bit.
    always_comb begin
        accExt = {work[64], work[64:33]};
        case (work[1:0])
            2'b01:   boothSum = accExt + {aReg[31], aReg};
            2'b10:   boothSum = accExt - {aReg[31], aReg};
            default: boothSum = accExt;
        endcase
        mulNext = {boothSum, work[32:1]};
    end

`ifdef MULDIV_DIV_EN
    logic        opReg;
    logic [31:0] bReg;
    logic [31:0] divisorMag;
    logic [31:0] dividendMagIn;
    logic [32:0] remShift;
    logic [32:0] remDiff;
    logic [64:0] divNext;
    logic [31:0] quoMag;
    logic [31:0] remMag;

    always_comb begin
        divisorMag    = bReg[31] ? -bReg : bReg;
        dividendMagIn = a[31] ? -a : a;
        remShift      = {work[63:32], work[31]};
        remDiff       = remShift - {1'b0, divisorMag};
        divNext       = remDiff[32] ? {remShift, work[30:0], 1'b0}
                                    : {remDiff,  work[30:0], 1'b1};
        quoMag        = divNext[31:0];
        remMag        = divNext[63:32];
        workNext      = opReg ? divNext : mulNext;
        resHi         = mulNext[64:33];
        resLo         = mulNext[32:1];
        if (opReg) begin
            resLo = (aReg[31] ^ bReg[31]) ? -quoMag : quoMag;
            resHi = aReg[31] ? -remMag : remMag;
        end
    end
`else
    always_comb begin
        workNext = mulNext;
        resHi    = mulNext[64:33];
        resLo    = mulNext[32:1];
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            iterCnt  <= 6'd0;
            aReg     <= 32'd0;
            work     <= 65'd0;
            hi       <= 32'd0;
            lo       <= 32'd0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
`ifdef MULDIV_DIV_EN
            opReg    <= 1'b0;
            bReg     <= 32'd0;
`endif
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        aReg    <= a;
                        iterCnt <= 6'd0;
                        work    <= {32'd0, b, 1'b0};
`ifdef MULDIV_DIV_EN
                        opReg   <= op;
                        bReg    <= b;
                        if (op) begin
                            work <= {33'd0, dividendMagIn};
                            if (b == 32'd0) begin
                                state    <= DONE;
                                done     <= 1'b1;
                                div_zero <= 1'b1;
                            end else begin
                                state <= RUN;
                                busy  <= 1'b1;
                            end
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
`else
                        if (op) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end
`endif
                    end
                end
                RUN: begin
                    work    <= workNext;
                    iterCnt <= iterCnt + 6'd1;
                    if (iterCnt == 6'd31) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        hi    <= resHi;
                        lo    <= resLo;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: timeline reference model compared every cycle plus literal result checks.
module tb_muldiv_unit;
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_zero;

    muldiv_unit dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    int passCnt  = 0;
    int totalCnt = 0;
    bit cmpEn    = 1'b0;
    int doneSeen = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        totalCnt++;
        if (act !== exp) $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        else passCnt++;
    endtask

    // Reference model: an accepted request completes L edges later (L = 32, or 0 when no
    // arithmetic is performed); the unit is deaf to start until the edge after completion.
    longint      cyc = 0;
    bit          active = 1'b0;
    longint      doneEdge;
    bit          pendWrite, pendDz;
    logic [31:0] pendHi, pendLo;
    logic [31:0] expHi, expLo;
    bit          expBusy, expDone, expDz;

    always @(posedge clk) begin
        longint prod, quo, rem, lat;
        cyc++;
        expDone = 1'b0;
        expDz   = 1'b0;
        if (reset) begin
            active  = 1'b0;
            expBusy = 1'b0;
            expHi   = 32'd0;
            expLo   = 32'd0;
        end else if (active) begin
            if (cyc == doneEdge) begin
                expBusy = 1'b0;
                expDone = 1'b1;
                expDz   = pendDz;
                if (pendWrite) begin
                    expHi = pendHi;
                    expLo = pendLo;
                end
            end else if (cyc == doneEdge + 1) begin
                active = 1'b0;
            end
        end else if (start) begin
            pendWrite = 1'b1;
            pendDz    = 1'b0;
            lat       = 32;
            if (!op) begin
                prod   = longint'($signed(a)) * longint'($signed(b));
                pendHi = prod[63:32];
                pendLo = prod[31:0];
            end else begin
`ifdef MULDIV_DIV_EN
                if (b == 32'd0) begin
                    pendWrite = 1'b0;
                    pendDz    = 1'b1;
                    lat       = 0;
                end else begin
                    quo    = longint'($signed(a)) / longint'($signed(b));
                    rem    = longint'($signed(a)) % longint'($signed(b));
                    pendLo = quo[31:0];
                    pendHi = rem[31:0];
                end
`else
                pendWrite = 1'b0;
                lat       = 0;
`endif
            end
            active   = 1'b1;
            doneEdge = cyc + lat;
            if (lat == 0) begin
                expDone = 1'b1;
                expDz   = pendDz;
            end else begin
                expBusy = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (done) doneSeen++;
        if (cmpEn) begin
            check("cyc busy",     busy,     expBusy);
            check("cyc done",     done,     expDone);
            check("cyc div_zero", div_zero, expDz);
            check("cyc hi",       hi,       expHi);
            check("cyc lo",       lo,       expLo);
        end
    end

    // Entered and left at posedge+2; inputs are scrambled after the start edge.
    task automatic runOp(input string name, input logic o, input logic [31:0] av, input logic [31:0] bv,
                         input int expLat, input logic expDzV,
                         input logic [31:0] expHiV, input logic [31:0] expLoV);
        longint s;
        int     busyCnt = 0;
        int     lat = -1;
        bit     seen = 1'b0;
        logic   dzAtDone = 1'b0;
        start = 1'b1; op = o; a = av; b = bv;
        @(posedge clk); #2;
        start = 1'b0;
        s = cyc;
        a = $urandom; b = $urandom; op = 1'($urandom_range(1));
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (busy) busyCnt++;
            if (done) begin
                seen     = 1'b1;
                lat      = int'(cyc - s);
                dzAtDone = div_zero;
            end
        end
        check({name, " done seen"}, seen, 1);
        check({name, " done edge offset"}, lat, expLat);
        check({name, " busy cycles"}, busyCnt, expLat);
        check({name, " div_zero"}, dzAtDone, expDzV);
        check({name, " hi"}, hi, expHiV);
        check({name, " lo"}, lo, expLoV);
        @(posedge clk); #2;
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int dBefore;
        reset = 1'b1; start = 1'b0; op = 1'b0; a = 32'd0; b = 32'd0;
        @(posedge clk); #2;
        cmpEn = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        check("reset hi", hi, 0);
        check("reset lo", lo, 0);
        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset div_zero", div_zero, 0);
        @(posedge clk); #2;

        runOp("mul -3x7",      1'b0, 32'hFFFFFFFD, 32'd7,        32, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFEB);
        runOp("mul min x min", 1'b0, 32'h80000000, 32'h80000000, 32, 1'b0, 32'h40000000, 32'h00000000);
        runOp("mul -1x-1",     1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, 1'b0, 32'h00000000, 32'h00000001);
        runOp("mul max x min", 1'b0, 32'h7FFFFFFF, 32'h80000000, 32, 1'b0, 32'hC0000000, 32'h80000000);
        runOp("mul preset",    1'b0, 32'h66666666, 32'h2AAAAAAB, 32, 1'b0, 32'h11111111, 32'h22222222);

`ifdef MULDIV_DIV_EN
        runOp("div 5/0",       1'b1, 32'd5,        32'd0,        0,  1'b1, 32'h11111111, 32'h22222222);
        runOp("div -7/2",      1'b1, 32'hFFFFFFF9, 32'd2,        32, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFD);
        runOp("div min/-1",    1'b1, 32'h80000000, 32'hFFFFFFFF, 32, 1'b0, 32'h00000000, 32'h80000000);
        runOp("div 100/-7",    1'b1, 32'd100,      32'hFFFFFFF9, 32, 1'b0, 32'h00000002, 32'hFFFFFFF2);
`else
        runOp("div disabled",  1'b1, 32'd9,        32'd3,        0,  1'b0, 32'h11111111, 32'h22222222);
`endif

        // Ignored restart at +10, reset at +20: no completion and cleared results.
        dBefore = doneSeen;
        start = 1'b1; op = 1'b0; a = 32'd6; b = 32'd7;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        start = 1'b1; op = 1'b1; a = 32'd9; b = 32'd0;
        @(posedge clk); #2;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        check("abort no done", doneSeen - dBefore, 0);
        check("abort hi", hi, 0);
        check("abort lo", lo, 0);
        check("abort busy", busy, 0);
        @(posedge clk); #2;
        runOp("mul 6x7 after reset", 1'b0, 32'd6, 32'd7, 32, 1'b0, 32'd0, 32'd42);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", passCnt, totalCnt);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 The block SHALL have one clock and use synchronous, active-high reset; the ports SHALL be named clk and reset.
REQ-002 The block SHALL expose these ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- op  in  1  0 = signed multiply (MULT), 1 = signed divide (DIV)
- a  in  32  multiplicand / dividend (driven from register A output)
- b  in  32  multiplier / divisor (driven from register B output)
- hi  out  32  HI result register (product[63:32] / remainder)
- lo  out  32  LO result register (product[31:0] / quotient)
- busy  out  1  high while in RUN
- done  out  1  one-cycle completion pulse
- div_zero  out  1  high together with done when DIV had b == 0

Function
REQ-003 The FSM SHALL have states IDLE, RUN and DONE.
REQ-004 In IDLE with start=1 at edge N, the block SHALL latch a, b and op, and clear the 6-bit iteration counter.
REQ-005 The entry state after edge N SHALL be RUN, except for a DIV with b == 0, which SHALL enter DONE.
REQ-006 RUN SHALL execute exactly 32 iterations, one per cycle; after the 32nd iteration (edge N+32) the FSM SHALL enter DONE.
REQ-007 DONE SHALL last one cycle and return to IDLE; done=1 only in DONE; busy=1 only in RUN.
REQ-008 The hi/lo registers SHALL be written on the edge that enters DONE and SHALL hold their value until the next completion; intermediate values SHALL never appear on hi/lo.
REQ-009 MULT SHALL use radix-2 Booth recoding over a 65-bit {acc, multiplier, q-1} register with arithmetic shift right.
REQ-010 The MULT result SHALL be the exact signed 64-bit product {hi, lo}.
REQ-011 DIV SHALL use 32-step restoring division on the magnitudes of a and b, followed by a sign correction.
REQ-012 DIV results: lo = quotient truncated toward zero; hi = remainder with the sign of the dividend.
REQ-013 DIV with a = 0x80000000 and b = 0xFFFFFFFF SHALL yield lo = 0x80000000 and hi = 0 (wrap, no trap).
REQ-014 DIV with b == 0 SHALL leave hi/lo unchanged and assert div_zero=1 during DONE (1 cycle after start); div_zero=0 at all other times.
REQ-015 start asserted in RUN or DONE SHALL be ignored; it SHALL neither be queued nor restart the operation.
REQ-016 Changes on a, b or op after the start edge SHALL have no effect on the operation in progress.
REQ-017 A MULT SHALL have a fixed latency of 33 cycles from the start edge to the done cycle.

Reset
REQ-018 reset=1 at a rising edge SHALL force: state=IDLE, counter=0, hi=0, lo=0, busy=0, done=0, div_zero=0, and clear the internal operand registers.
REQ-019 reset SHALL take priority over start.
REQ-020 reset during RUN SHALL abort the operation without producing a done pulse.
REQ-021 The first start after reset is deasserted SHALL be accepted normally.

Configuration
REQ-022 The macro MULDIV_DIV_EN SHALL compile the divider datapath in or out.
REQ-023 With MULDIV_DIV_EN defined, behaviour SHALL be as in REQ-011 through REQ-014.
REQ-024 With MULDIV_DIV_EN undefined, the divider logic SHALL be absent.
REQ-025 With MULDIV_DIV_EN undefined, op=1 with start SHALL go directly to DONE (done one cycle after start) with hi/lo unchanged, and div_zero SHALL be tied to 0.
REQ-026 With MULDIV_DIV_EN undefined, MULT behaviour SHALL be identical to the enabled build.

Verification
REQ-027 MULT a=0xFFFFFFFD (-3), b=7 -> done at start+33: hi=0xFFFFFFFF, lo=0xFFFFFFEB; busy high for exactly 32 cycles.
REQ-028 MULT a=0x80000000, b=0x80000000 -> hi=0x40000000, lo=0x00000000.
REQ-029 DIV a=0xFFFFFFF9 (-7), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF, div_zero=0; then DIV a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-030 With hi=0x11111111 and lo=0x22222222, DIV a=5, b=0 -> done and div_zero both high 1 cycle after start; hi/lo unchanged; busy never high.
REQ-031 Start MULT 6x7; re-pulse start with op=1 at start+10; assert reset=1 at start+20 for one cycle -> no done pulse; hi=lo=0; a subsequent MULT 6x7 completes with lo=42, hi=0.
REQ-032 Build without MULDIV_DIV_EN; DIV a=9, b=3 -> done 1 cycle after start; hi/lo unchanged; div_zero=0.
